// File: rtl/delay_table_sequencer.sv
// rtl/delay_table_sequencer.sv - delay table store and boot/update stream sequencer for global_controller
// Holds the per-object delay table with dirty tracking and replays it as boot
// (all entries) or update (dirty entries only) element streams.
// Issue decisions are taken on the edge that enters a scan cycle so that the
// registered strobe and data appear in that scan cycle itself.
module delay_table_sequencer #(
  parameter int N_obj        = 4,
  parameter int obj_id_width = 2,
  parameter int delay_length = 14,
  parameter int LEAD_CYC     = 5,
  parameter int GAP_CYC      = 6,
  parameter int TAIL_CYC     = 5
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic                    cfg_wr_en,
  input  logic [obj_id_width-1:0] cfg_wr_obj,
  input  logic [delay_length-1:0] cfg_wr_delay,
  input  logic                    load_start,
  input  logic                    update_start,
  output logic                    boot_up,
  output logic                    input_valid,
  output logic                    table_parse,
  output logic                    glob_scen_noc_input_valid,
  output logic [delay_length-1:0] delay_matrix_element,
  output logic [obj_id_width-1:0] obj_id_element,
  output logic                    busy,
  output logic                    done
);

  localparam int CNT_W = 8;
  localparam logic [obj_id_width-1:0] LAST_P = obj_id_width'(N_obj - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_SCAN,
    S_GAP,
    S_TAIL
  } state_t;

  state_t                  r_state, w_next_state;
  logic [obj_id_width-1:0] r_p, w_next_p;
  logic [CNT_W-1:0]        r_cnt, w_next_cnt;
  logic                    r_boot_mode;
  logic                    w_load_acc, w_upd_acc, w_enter_scan, w_finish, w_issue;

  logic [delay_length-1:0] r_table [N_obj];
  logic [N_obj-1:0]        r_dirty;

  logic                    r_boot_up, r_input_valid, r_table_parse, r_glob_valid;
  logic [delay_length-1:0] r_delay;
  logic [obj_id_width-1:0] r_obj_id;
  logic                    r_busy, r_done;

  // State, scan pointer, phase counter and stream mode registers.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_p         <= '0;
      r_cnt       <= '0;
      r_boot_mode <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_p     <= w_next_p;
      r_cnt   <= w_next_cnt;
      if (w_load_acc) begin
        r_boot_mode <= 1'b1;
      end else if (w_upd_acc) begin
        r_boot_mode <= 1'b0;
      end
    end
  end

  // Next-state logic; w_enter_scan marks edges that open a scan cycle for w_next_p.
  always_comb begin
    w_next_state = r_state;
    w_next_p     = r_p;
    w_next_cnt   = r_cnt;
    w_load_acc   = 1'b0;
    w_upd_acc    = 1'b0;
    w_enter_scan = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (load_start || update_start) begin
          w_load_acc   = load_start;
          w_upd_acc    = !load_start;
          w_next_state = S_LEAD;
          w_next_p     = '0;
          w_next_cnt   = CNT_W'(LEAD_CYC - 1);
        end
      end
      S_LEAD: begin
        if (r_cnt == '0) begin
          w_next_state = S_SCAN;
          w_next_p     = '0;
          w_enter_scan = 1'b1;
        end else begin
          w_next_cnt = r_cnt - 1'b1;
        end
      end
      S_SCAN: begin
        if (r_p == LAST_P) begin
          w_next_state = S_TAIL;
          w_next_cnt   = CNT_W'(TAIL_CYC - 1);
        end else if (r_input_valid || r_glob_valid) begin
          w_next_state = S_GAP;
          w_next_cnt   = CNT_W'(GAP_CYC - 1);
        end else begin
          w_next_p     = r_p + 1'b1;
          w_enter_scan = 1'b1;
        end
      end
      S_GAP: begin
        if (r_cnt == '0) begin
          w_next_state = S_SCAN;
          w_next_p     = r_p + 1'b1;
          w_enter_scan = 1'b1;
        end else begin
          w_next_cnt = r_cnt - 1'b1;
        end
      end
      S_TAIL: begin
        if (r_cnt == '0) begin
          w_next_state = S_IDLE;
          w_finish     = 1'b1;
        end else begin
          w_next_cnt = r_cnt - 1'b1;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_issue = w_enter_scan && (r_boot_mode || r_dirty[w_next_p]);

  // Table and dirty bits; a write on the issuing edge re-marks the entry dirty.
  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int i = 0; i < N_obj; i++) begin
        r_table[i] <= '0;
      end
      r_dirty <= '0;
    end else begin
      if (w_issue) begin
        r_dirty[w_next_p] <= 1'b0;
      end
      if (cfg_wr_en) begin
        r_table[cfg_wr_obj] <= cfg_wr_delay;
        r_dirty[cfg_wr_obj] <= 1'b1;
      end
    end
  end

  // Registered outputs: strobes, held element data, phase flags, busy and done.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_boot_up     <= 1'b0;
      r_input_valid <= 1'b0;
      r_table_parse <= 1'b0;
      r_glob_valid  <= 1'b0;
      r_delay       <= '0;
      r_obj_id      <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_input_valid <= w_issue && r_boot_mode;
      r_glob_valid  <= w_issue && !r_boot_mode;
      if (w_issue) begin
        r_delay  <= r_table[w_next_p];
        r_obj_id <= w_next_p;
      end
      r_busy <= (w_next_state != S_IDLE);
      r_done <= w_finish;
      if (w_load_acc) begin
        r_boot_up     <= 1'b1;
        r_table_parse <= 1'b0;
      end else if (w_upd_acc) begin
        r_table_parse <= 1'b1;
      end else if (w_finish && r_boot_mode) begin
        r_boot_up <= 1'b0;
      end
    end
  end

  assign boot_up                   = r_boot_up;
  assign input_valid               = r_input_valid;
  assign table_parse               = r_table_parse;
  assign glob_scen_noc_input_valid = r_glob_valid;
  assign delay_matrix_element      = r_delay;
  assign obj_id_element            = r_obj_id;
  assign busy                      = r_busy;
  assign done                      = r_done;

endmodule

// File: tb/tb_delay_table_sequencer.sv
// tb/tb_delay_table_sequencer.sv - scoreboard bench for delay_table_sequencer
module tb_delay_table_sequencer;

  localparam int N_OBJ = 4;
  localparam int ID_W  = 2;
  localparam int DL    = 14;
  localparam int LEAD  = 5;
  localparam int GAP   = 6;
  localparam int TAIL  = 5;

  logic            CLK = 1'b0;
  logic            reset, cfg_wr_en, load_start, update_start;
  logic [ID_W-1:0] cfg_wr_obj;
  logic [DL-1:0]   cfg_wr_delay;
  logic            boot_up, input_valid, table_parse, glob_scen_noc_input_valid;
  logic [DL-1:0]   delay_matrix_element;
  logic [ID_W-1:0] obj_id_element;
  logic            busy, done;

  delay_table_sequencer #(
    .N_obj(N_OBJ), .obj_id_width(ID_W), .delay_length(DL),
    .LEAD_CYC(LEAD), .GAP_CYC(GAP), .TAIL_CYC(TAIL)
  ) dut (
    .CLK(CLK), .reset(reset), .cfg_wr_en(cfg_wr_en), .cfg_wr_obj(cfg_wr_obj),
    .cfg_wr_delay(cfg_wr_delay), .load_start(load_start), .update_start(update_start),
    .boot_up(boot_up), .input_valid(input_valid), .table_parse(table_parse),
    .glob_scen_noc_input_valid(glob_scen_noc_input_valid),
    .delay_matrix_element(delay_matrix_element), .obj_id_element(obj_id_element),
    .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  int edge_cnt = 0;
  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int cyc;
    bit boot;
    int d;
    int id;
  } ev_t;

  ev_t exp_q[$];
  ev_t done_q[$];

  int m_table [N_OBJ];
  bit m_dirty [N_OBJ];
  bit m_parse = 1'b0;
  int m_last_d = 0;
  int m_last_id = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, edge_cnt + 1);
    end
  endtask

  // Stream plan from the rules: entry k is scanned at first_scan + k + issued_before*GAP.
  function automatic int plan(input int t, input bit boot);
    int scan = t + 1 + LEAD;
    int n = 0;
    int c = 0;
    for (int k = 0; k < N_OBJ; k++) begin
      c = scan + k + n * GAP;
      if (boot || m_dirty[k]) begin
        exp_q.push_back('{c, boot, m_table[k], k});
        m_dirty[k] = 1'b0;
        m_last_d = m_table[k];
        m_last_id = k;
        n++;
      end
    end
    done_q.push_back('{c + 1 + TAIL, boot, m_last_d, m_last_id});
    return c + 1 + TAIL;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a strobe or done.
  always @(negedge CLK) begin
    automatic int cur = edge_cnt + 1;
    ev_t e;
    if (input_valid || glob_scen_noc_input_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("strobe_cycle", longint'(cur), longint'(e.cyc));
        check("strobe_input_valid", longint'(input_valid), longint'(e.boot));
        check("strobe_glob_valid", longint'(glob_scen_noc_input_valid), longint'(!e.boot));
        check("strobe_delay", longint'(delay_matrix_element), longint'(e.d));
        check("strobe_obj_id", longint'(obj_id_element), longint'(e.id));
      end
    end
    if (done) begin
      if (done_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = done_q.pop_front();
        check("done_cycle", longint'(cur), longint'(e.cyc));
        check("done_boot_up", longint'(boot_up), 0);
        check("done_busy", longint'(busy), 0);
        check("hold_delay", longint'(delay_matrix_element), longint'(e.d));
        check("hold_obj_id", longint'(obj_id_element), longint'(e.id));
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic go_to(input int c);
    while (edge_cnt + 1 < c) step();
  endtask

  task automatic wr(input int obj, input int val);
    cfg_wr_en    = 1'b1;
    cfg_wr_obj   = ID_W'(obj);
    cfg_wr_delay = DL'(val);
    m_table[obj] = val;
    m_dirty[obj] = 1'b1;
    step();
    cfg_wr_en = 1'b0;
  endtask

  task automatic begin_stream(input bit ld, input bit up, output int t, output int dc);
    t = edge_cnt + 1;
    load_start   = ld;
    update_start = up;
    if (ld) begin
      m_parse = 1'b0;
      dc = plan(t, 1'b1);
    end else begin
      m_parse = 1'b1;
      dc = plan(t, 1'b0);
    end
    step();
    load_start   = 1'b0;
    update_start = 1'b0;
    check("flag_boot_up", longint'(boot_up), longint'(ld));
    check("flag_table_parse", longint'(table_parse), longint'(m_parse));
    check("busy_start", longint'(busy), 1);
  endtask

  task automatic finish_stream(input int dc);
    go_to(dc + 1);
    check("after_boot_up", longint'(boot_up), 0);
    check("after_table_parse", longint'(table_parse), longint'(m_parse));
    check("after_busy", longint'(busy), 0);
    check("after_done", longint'(done), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_boot_up"}, longint'(boot_up), 0);
    check({tag, "_input_valid"}, longint'(input_valid), 0);
    check({tag, "_table_parse"}, longint'(table_parse), 0);
    check({tag, "_glob_valid"}, longint'(glob_scen_noc_input_valid), 0);
    check({tag, "_delay"}, longint'(delay_matrix_element), 0);
    check({tag, "_obj_id"}, longint'(obj_id_element), 0);
    check({tag, "_busy"}, longint'(busy), 0);
    check({tag, "_done"}, longint'(done), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int t, dc, c2;
    reset = 1'b1; cfg_wr_en = 1'b0; cfg_wr_obj = '0; cfg_wr_delay = '0;
    load_start = 1'b0; update_start = 1'b0;
    for (int k = 0; k < N_OBJ; k++) begin
      m_table[k] = 0;
      m_dirty[k] = 1'b0;
    end
    repeat (3) step();
    reset = 1'b0;
    step();
    check_all_zero("reset");

    // Boot of the whole table.
    wr(0, 500); wr(1, 400); wr(2, 3000); wr(3, 4000);
    begin_stream(1'b1, 1'b0, t, dc);
    finish_stream(dc);

    // Update with one rewritten entry, then with nothing dirty.
    wr(1, 400);
    begin_stream(1'b0, 1'b1, t, dc);
    finish_stream(dc);
    begin_stream(1'b0, 1'b1, t, dc);
    finish_stream(dc);

    // Both requests together: boot wins; mid-stream update ignored; collision on obj2.
    begin_stream(1'b1, 1'b1, t, dc);
    go_to(t + 8);
    update_start = 1'b1;
    step();
    update_start = 1'b0;
    c2 = t + 1 + LEAD + 2 + 2 * GAP;
    go_to(c2);
    wr(2, 1234);
    finish_stream(dc);

    // Update issues the collided write; obj0 written after it was passed.
    begin_stream(1'b0, 1'b1, t, dc);
    go_to(t + 1 + LEAD + 4);
    wr(0, 77);
    finish_stream(dc);
    begin_stream(1'b0, 1'b1, t, dc);
    finish_stream(dc);

    // Reset mid-boot aborts the stream and clears the table.
    begin_stream(1'b1, 1'b0, t, dc);
    go_to(t + 15);
    reset = 1'b1;
    step();
    while (exp_q.size() > 0 && exp_q[exp_q.size() - 1].cyc > t + 15) void'(exp_q.pop_back());
    done_q.delete();
    check_all_zero("midreset");
    reset = 1'b0;
    for (int k = 0; k < N_OBJ; k++) begin
      m_table[k] = 0;
      m_dirty[k] = 1'b0;
    end
    m_parse = 1'b0; m_last_d = 0; m_last_id = 0;
    repeat (20) step();
    begin_stream(1'b1, 1'b0, t, dc);
    finish_stream(dc);

    // Randomized writes and stream requests while idle.
    for (int r = 0; r < 12; r++) begin
      int nw = $urandom_range(0, 3);
      int sel;
      for (int w = 0; w < nw; w++) wr($urandom_range(0, N_OBJ - 1), $urandom_range(0, 16383));
      repeat ($urandom_range(0, 3)) step();
      sel = $urandom_range(0, 3);
      begin_stream(sel <= 1, sel != 1, t, dc);
      finish_stream(dc);
    end

    repeat (5) step();
    check("strobes_outstanding", longint'(exp_q.size()), 0);
    check("dones_outstanding", longint'(done_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
